// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// One operation in flight: accept (IDLE) -> EXEC (ALU settles) -> RESP (hold until consumed).
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic [1:0]           req0_op,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    input  logic [1:0]           req1_op,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [1:0]           alu_opcode,
    input  logic [2*WIDTH-1:0]   alu_result,
    input  logic                 alu_n,
    input  logic                 alu_z,
    input  logic                 alu_c,
    input  logic                 alu_v,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic [3:0]           rsp_flags,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               r_state, w_next;
    logic                 r_last_grant;
    logic                 r_id;
    logic [WIDTH-1:0]     r_alu_a, r_alu_b;
    logic [1:0]           r_alu_op;
    logic                 r_rsp_valid, r_rsp_id;
    logic [2*WIDTH-1:0]   r_rsp_result;
    logic [3:0]           r_rsp_flags;
    logic                 w_grant1, w_acc0, w_acc1;

    // On a tie the requester not served last wins; otherwise whoever is asking.
    always_comb begin
        w_grant1   = (req0_valid && req1_valid) ? !r_last_grant : req1_valid;
        req0_ready = (r_state == IDLE) && req0_valid && !w_grant1 && !rst;
        req1_ready = (r_state == IDLE) && req1_valid &&  w_grant1 && !rst;
        w_acc0     = req0_valid && req0_ready;
        w_acc1     = req1_valid && req1_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc0 || w_acc1) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= 2'b00;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= 4'b0000;
        end else begin
            if (w_acc0) begin
                r_alu_a      <= req0_a;
                r_alu_b      <= req0_b;
                r_alu_op     <= req0_op;
                r_id         <= 1'b0;
                r_last_grant <= 1'b0;
            end else if (w_acc1) begin
                r_alu_a      <= req1_a;
                r_alu_b      <= req1_b;
                r_alu_op     <= req1_op;
                r_id         <= 1'b1;
                r_last_grant <= 1'b1;
            end
            // ALU output has had the whole EXEC cycle to settle.
            if (r_state == EXEC) begin
                r_rsp_result <= alu_result;
                r_rsp_flags  <= {alu_n, alu_z, alu_c, alu_v};
                r_rsp_id     <= r_id;
                r_rsp_valid  <= 1'b1;
            end else if (r_state == RESP && rsp_ready) begin
                r_rsp_valid  <= 1'b0;
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the alu_* port.
module tb_alu_arbiter;
    localparam int W = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic req0_valid = 0, req1_valid = 0, rsp_ready = 0;
    logic req0_ready, req1_ready;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [1:0] req0_op = 0, req1_op = 0;
    logic [W-1:0] alu_a, alu_b;
    logic [1:0] alu_opcode;
    logic [2*W-1:0] alu_result, rsp_result;
    logic alu_n, alu_z, alu_c, alu_v;
    logic rsp_valid, rsp_id, busy;
    logic [3:0] rsp_flags;

    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    // Behavioural ALU: zero-extended operands, N/Z from the 2W-bit result, C/V never set.
    always_comb begin
        case (alu_opcode)
            2'b00:   alu_result = {{W{1'b0}}, alu_a} + {{W{1'b0}}, alu_b};
            2'b01:   alu_result = {{W{1'b0}}, alu_a} - {{W{1'b0}}, alu_b};
            2'b10:   alu_result = {{W{1'b0}}, alu_a & alu_b};
            default: alu_result = {{W{1'b0}}, alu_a | alu_b};
        endcase
        alu_n = alu_result[2*W-1];
        alu_z = (alu_result == '0);
        alu_c = 1'b0;
        alu_v = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic id, input logic [7:0] res, input logic [3:0] fl);
        chk({tag, "_vld"}, rsp_valid, 1);
        chk({tag, "_id"}, rsp_id, id);
        chk({tag, "_res"}, rsp_result, res);
        chk({tag, "_flg"}, rsp_flags, fl);
    endtask

    initial begin
        // Reset with both requesters asking.
        req0_valid = 1; req1_valid = 1;
        tick(); tick();
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_rvld", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
        chk("rst_rsp", {rsp_id, rsp_result, rsp_flags}, 0);
        rst = 0; #1;
        chk("rel_rdy0", req0_ready, 1);
        chk("rel_rdy1", req1_ready, 0);

        // Single add from req0: 9 + 8 = 0x11.
        req1_valid = 0; req0_a = 4'd9; req0_b = 4'd8; req0_op = 2'b00; rsp_ready = 1;
        tick();
        req0_valid = 0;
        chk("add_busy", busy, 1);
        chk("add_alu", {alu_a, alu_b, alu_opcode}, {4'd9, 4'd8, 2'b00});
        chk("add_rvld0", rsp_valid, 0);
        tick();
        chk_rsp("add", 0, 8'h11, 4'b0000);
        tick();
        chk("add_done_vld", rsp_valid, 0);
        chk("add_done_busy", busy, 0);

        // Backpressure: req1 sub 3 - 5 = 0xFE, N set; held for 5 cycles.
        req1_valid = 1; req1_a = 4'd3; req1_b = 4'd5; req1_op = 2'b01; rsp_ready = 0;
        #1 chk("bp_rdy1", req1_ready, 1);
        tick();
        req1_valid = 0;
        tick();
        chk_rsp("bp", 1, 8'hFE, 4'b1000);
        req0_valid = 1; req0_a = 4'hC; req0_b = 4'hA; req0_op = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_rsp("bp_hold", 1, 8'hFE, 4'b1000);
            chk("bp_rdy0", req0_ready, 0);
            chk("bp_rdy1h", req1_ready, 0);
        end
        req0_valid = 0;
        rsp_ready = 1;
        tick();
        chk("bp_drop", rsp_valid, 0);
        req0_valid = 1;
        #1 chk("bp_regrant", req0_ready, 1);

        // Round robin: req0 AND C&A = 0x08, req1 OR 0|0 = 0x00 (Z).
        req1_valid = 1; req1_a = 0; req1_b = 0; req1_op = 2'b11;
        for (int i = 0; i < 4; i++) begin
            chk("rr_rdy0", req0_ready, (i % 2 == 0));
            chk("rr_rdy1", req1_ready, (i % 2 == 1));
            tick(); tick();
            if (i % 2 == 0) chk_rsp("rr0", 0, 8'h08, 4'b0000);
            else            chk_rsp("rr1", 1, 8'h00, 4'b0100);
            tick();
        end
        req0_valid = 0; req1_valid = 0;

        // Reset during EXEC discards the op.
        req0_valid = 1; req0_a = 4'd1; req0_b = 4'd2; req0_op = 2'b00;
        tick();
        req0_valid = 0;
        chk("mid_busy", busy, 1);
        rst = 1; #1;
        chk("mid_busy0", busy, 0);
        chk("mid_alu0", {alu_a, alu_b, alu_opcode}, 0);
        tick();
        chk("mid_rvld", rsp_valid, 0);
        rst = 0;
        tick();
        chk("mid_rvld2", rsp_valid, 0);
        req0_valid = 1; req0_a = 4'd4; req0_b = 4'd4; req0_op = 2'b00;
        tick();
        req0_valid = 0;
        tick();
        chk_rsp("post", 0, 8'h08, 4'b0000);
        tick();

        // req1 pulses valid only while in RESP: never granted.
        req0_valid = 1; req0_a = 4'd7; req0_b = 4'd0; req0_op = 2'b11; rsp_ready = 0;
        tick();
        req0_valid = 0;
        tick();
        chk_rsp("wd", 0, 8'h07, 4'b0000);
        req1_valid = 1; req1_a = 4'd1; req1_b = 4'd1; req1_op = 2'b00;
        #1 chk("wd_rdy1", req1_ready, 0);
        tick();
        req1_valid = 0; rsp_ready = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wd_novld", rsp_valid, 0);
            chk("wd_idle", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational ALU between two requesters on the FPGA slave. Each requester submits an operation (A, B, opcode) over a valid/ready handshake. The block drives the ALU from registered operands and captures the result and flags. It then returns them on a single response channel tagged with the requester ID. Only one operation is in flight at a time.

## Interface
- WIDTH, 4, operand width; must match the ALU instance; result is 2*WIDTH bits
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req0_op  input  2  requester 0 opcode (00 add, 01 sub, 10 and, 11 or)
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- alu_a, alu_b  output  WIDTH  ALU operands (registered)
- alu_opcode  output  2  ALU opcode (registered)
- alu_result  input  2*WIDTH  ALU result
- alu_n, alu_z, alu_c, alu_v  input  1  ALU flags
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the operation
- rsp_result  output  2*WIDTH  captured result
- rsp_flags  output  4  captured flags {N,Z,C,V}
- busy  output  1  high in EXEC or RESP

## Operation
- FSM states: IDLE, EXEC, RESP; reset state IDLE.
- **IDLE, grant:**
  - Only req0_valid high: grant 0. Only req1_valid high: grant 1.
  - Both high: grant the requester not granted last (last_grant register; reset value 1, so req0 wins the first tie).
- **IDLE, ready and accept:**
  - reqN_ready = (state==IDLE) && granted==N && !rst; combinational; at most one ready high.
  - Handshake = valid && ready. On it: latch a/b/op into alu_a/alu_b/alu_opcode, store ID, update last_grant, go to EXEC.
- **EXEC:**
  - ALU settles from the registered inputs.
  - At the end of the cycle: rsp_result <= alu_result, rsp_flags <= {alu_n,alu_z,alu_c,alu_v}, rsp_id <= stored ID, rsp_valid <= 1, go to RESP.
- **RESP:**
  - Hold all rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid <= 0, go to IDLE.
  - No new request is accepted in RESP.
- The opcode is passed through unmodified. The block performs no arithmetic and does not reinterpret flags.
- alu_* outputs hold their last value after an operation completes; there is no clearing.
- A requester dropping valid before ready is tolerated; no grant occurs.
- Changing operands while valid && !ready is allowed; the values sampled at the handshake edge are used.

## Timing
- **Reset values:** state IDLE, last_grant 1, alu_a/alu_b 0, alu_opcode 00, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0000, busy 0, req0_ready/req1_ready 0 while rst high.
- **Latency:** handshake at edge k. alu_* valid after edge k. rsp_valid high after edge k+1, i.e. visible in the second cycle after the accepting cycle.
- **Throughput:** with rsp_ready held high, one operation per 3 cycles (accept, EXEC, RESP).
- rsp_ready backpressure stretches RESP indefinitely; both req ready signals stay low throughout.
- rst asserted mid-operation (EXEC or RESP): outputs immediately take reset values; the in-flight operation is discarded with no response.
- Simultaneous valid on both ports in consecutive arbitration windows alternates grants 0,1,0,1.

## Test plan
- **Reset:** rst high with both valids high → both readys 0, rsp_valid 0, all outputs 0; release rst, both valid → req0_ready 1 first.
- **Single add:** req0 a=9, b=8, op=00, rsp_ready=1 → after 2 edges rsp_valid=1, rsp_id=0, rsp_result=8'h11, rsp_flags=0000.
- **Round-robin:** both valid continuously, req0 AND (a=C, b=A), req1 OR (a=0, b=0), 4 ops → rsp_id sequence 0,1,0,1. AND results 8'h08 with Z=0; OR results 8'h00 with flags 0100.
- **Backpressure:** sub a=3, b=5 from req1, rsp_ready=0 for 5 cycles → rsp_valid and rsp_* stable, flags N=1, both readys 0. rsp_ready=1 → rsp_valid drops next edge, a new grant is possible in the following cycle.
- **Reset mid-op:** assert rst during EXEC → rsp_valid stays 0, no response emitted; after release the next request completes normally.
- **Valid withdrawal:** req1_valid pulses one cycle while FSM is in RESP → never granted, no response with rsp_id=1.
